// File: rtl/cache_mem_arbiter.sv
// Shares one RAM port among the icache/dcache memory sides of N_CORES cores.
// Round-robin across cores; within a core dcache write > dcache read > icache read.
module cache_mem_arbiter #(
  parameter int N_CORES = 2,
  parameter int AW      = 32,
  localparam int PW     = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [N_CORES-1:0]    iREN,
  input  logic [N_CORES*AW-1:0] iaddr,
  input  logic [N_CORES-1:0]    dREN,
  input  logic [N_CORES-1:0]    dWEN,
  input  logic [N_CORES*AW-1:0] daddr,
  input  logic [N_CORES*AW-1:0] dstore,
  output logic [N_CORES-1:0]    iwait,
  output logic [N_CORES-1:0]    dwait,
  output logic [N_CORES*AW-1:0] iload,
  output logic [N_CORES*AW-1:0] dload,
  output logic                  ramREN,
  output logic                  ramWEN,
  output logic [AW-1:0]         ramaddr,
  output logic [AW-1:0]         ramstore,
  input  logic [AW-1:0]         ramload,
  input  logic                  ram_ready,
  output logic                  dbg_state,
  output logic [PW-1:0]         dbg_rr_ptr
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {OP_IRD, OP_DRD, OP_DWR} op_t;

  state_t          state, next_state;
  op_t             op, sel_op;
  logic [PW-1:0]   rr_ptr, win_core, sel_core, idx;
  logic [AW-1:0]   lat_addr, lat_store, sel_addr, sel_store;
  logic            found;
  logic [N_CORES-1:0] req;
  logic [AW-1:0]   ia [N_CORES];
  logic [AW-1:0]   da [N_CORES];
  logic [AW-1:0]   ds [N_CORES];
  logic [AW-1:0]   il_a [N_CORES];
  logic [AW-1:0]   dl_a [N_CORES];

  for (genvar c = 0; c < N_CORES; c++) begin : g_core
    assign ia[c] = iaddr[c*AW +: AW];
    assign da[c] = daddr[c*AW +: AW];
    assign ds[c] = dstore[c*AW +: AW];
    assign iload[c*AW +: AW] = il_a[c];
    assign dload[c*AW +: AW] = dl_a[c];
  end

  assign req        = iREN | dREN | dWEN;
  assign dbg_state  = (state == BUSY);
  assign dbg_rr_ptr = rr_ptr;

  // Scan from rr_ptr; first core with any request wins.
  always_comb begin
    found     = 1'b0;
    idx       = '0;
    sel_core  = '0;
    sel_op    = OP_IRD;
    sel_addr  = '0;
    sel_store = '0;
    for (int k = 0; k < N_CORES; k++) begin
      idx = PW'((int'(rr_ptr) + k) % N_CORES);
      if (!found && req[idx]) begin
        found     = 1'b1;
        sel_core  = idx;
        sel_addr  = da[idx];
        sel_store = ds[idx];
        if (dWEN[idx]) begin
          sel_op = OP_DWR;
        end else if (dREN[idx]) begin
          sel_op = OP_DRD;
        end else begin
          sel_op    = OP_IRD;
          sel_addr  = ia[idx];
          sel_store = '0;
        end
      end
    end
  end

  // Handshake: a wait bit is 1 until its access completes; a single-cycle 0
  // on the ram_ready cycle marks completion, with load data valid only then.
  always_comb begin
    next_state = state;
    iwait      = '1;
    dwait      = '1;
    il_a       = '{default: '0};
    dl_a       = '{default: '0};
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    case (state)
      IDLE: if (found) next_state = BUSY;
      BUSY: begin
        ramREN   = (op != OP_DWR);
        ramWEN   = (op == OP_DWR);
        ramaddr  = lat_addr;
        ramstore = lat_store;
        if (ram_ready) begin
          next_state = IDLE;
          if (op == OP_IRD) begin
            iwait[win_core] = 1'b0;
            il_a[win_core]  = ramload;
          end else begin
            dwait[win_core] = 1'b0;
            if (op == OP_DRD) dl_a[win_core] = ramload;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      win_core  <= '0;
      op        <= OP_IRD;
      lat_addr  <= '0;
      lat_store <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && found) begin
        win_core  <= sel_core;
        op        <= sel_op;
        lat_addr  <= sel_addr;
        lat_store <= sel_store;
      end
      if (state == BUSY && ram_ready)
        rr_ptr <= (win_core == PW'(N_CORES - 1)) ? '0 : win_core + 1'b1;
    end
  end

endmodule
